// File: rtl/aes_key_arbiter_if.sv
// aes_key_arbiter_if
// Bundles the requester-side and expander-side signals of aes_key_arbiter.
//   slave  : the arbiter itself (takes requests and expander results,
//            drives grants, responses and the expander start/key)
//   master : the environment around it (requesters plus key expander)
// Signal groups:
//   req_valid_i / req_key_i / req_ready_o   request handshake, 2 requesters
//   rsp_valid_o / rsp_hit_o / round_key_o   response pulse and round keys
//   busy_o, flush_i                         status, cache invalidate
//   kx_start_o / kx_key_o / kx_done_i /
//   kx_round_key_i                          key-expander handshake
interface aes_key_arbiter_if;
   logic [1:0]   req_valid_i;
   logic [127:0] req_key_i [0:1];
   logic [1:0]   req_ready_o;
   logic [1:0]   rsp_valid_o;
   logic         rsp_hit_o;
   logic [127:0] round_key_o [0:10];
   logic         busy_o;
   logic         flush_i;
   logic         kx_start_o;
   logic [127:0] kx_key_o;
   logic         kx_done_i;
   logic [127:0] kx_round_key_i [0:10];

   modport slave (
      input  req_valid_i, req_key_i, flush_i, kx_done_i, kx_round_key_i,
      output req_ready_o, rsp_valid_o, rsp_hit_o, round_key_o, busy_o,
             kx_start_o, kx_key_o
   );

   modport master (
      output req_valid_i, req_key_i, flush_i, kx_done_i, kx_round_key_i,
      input  req_ready_o, rsp_valid_o, rsp_hit_o, round_key_o, busy_o,
             kx_start_o, kx_key_o
   );
endinterface

// File: rtl/aes_key_arbiter.sv
// aes_key_arbiter
// Shares one AES-128 key-expansion unit between two requesters with
// round-robin arbitration, and skips re-expansion when the granted key
// equals the most recently expanded (and still valid) key.
// Ports:
//   clk  : sole clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : aes_key_arbiter_if.slave (request/response and expander signals)
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | arbitrate, accept one request, decide hit or miss
// START | one-cycle start pulse to the expander
// WAIT  | wait for the expander done pulse
// RESP  | one-cycle response pulse to the granted requester
module aes_key_arbiter (
   input logic        clk,
   input logic        rst,
   aes_key_arbiter_if.slave bus
);

   typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

   state_t       state_q, state_d;
   logic         last_q, last_d;
   logic         gnt_q, gnt_d;
   logic         cache_valid_q, cache_valid_d;
   logic         flush_seen_q, flush_seen_d;
   logic [127:0] cache_key_q, cache_key_d;
   logic [127:0] kx_key_q, kx_key_d;
   logic [1:0]   rsp_valid_q, rsp_valid_d;
   logic         rsp_hit_q, rsp_hit_d;
   logic         kx_start_q, kx_start_d;
   logic         busy_q, busy_d;

   logic         arb_gnt;
   logic [1:0]   ready;
   logic         hs;
   logic         hit;

   // On a tie the requester that was not granted last time wins.
   always_comb begin
      arb_gnt = (bus.req_valid_i == 2'b11) ? ~last_q : bus.req_valid_i[1];
      ready   = 2'b00;
      if (state_q == IDLE && !rst && (bus.req_valid_i != 2'b00))
         ready = arb_gnt ? 2'b10 : 2'b01;
      hs  = (ready & bus.req_valid_i) != 2'b00;
      hit = cache_valid_q && (bus.req_key_i[arb_gnt] == cache_key_q) && !bus.flush_i;
   end

   always_comb begin
      state_d       = state_q;
      last_d        = last_q;
      gnt_d         = gnt_q;
      cache_valid_d = cache_valid_q;
      flush_seen_d  = flush_seen_q;
      cache_key_d   = cache_key_q;
      kx_key_d      = kx_key_q;
      rsp_valid_d   = 2'b00;
      rsp_hit_d     = 1'b0;
      kx_start_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (hs) begin
               gnt_d    = arb_gnt;
               last_d   = arb_gnt;
               kx_key_d = bus.req_key_i[arb_gnt];
               if (hit) begin
                  state_d     = RESP;
                  rsp_valid_d = arb_gnt ? 2'b10 : 2'b01;
                  rsp_hit_d   = 1'b1;
               end else begin
                  // Cache is invalid until this expansion completes cleanly.
                  cache_valid_d = 1'b0;
                  cache_key_d   = bus.req_key_i[arb_gnt];
                  state_d       = START;
                  kx_start_d    = 1'b1;
               end
            end
         end
         START: begin
            state_d = WAIT;
            if (bus.flush_i) flush_seen_d = 1'b1;
         end
         WAIT: begin
            if (bus.flush_i) flush_seen_d = 1'b1;
            if (bus.kx_done_i) begin
               cache_valid_d = !flush_seen_q;
               state_d       = RESP;
               rsp_valid_d   = gnt_q ? 2'b10 : 2'b01;
            end
         end
         RESP: begin
            state_d      = IDLE;
            flush_seen_d = 1'b0;
         end
         default: state_d = IDLE;
      endcase
      // A flush always wins, including one coincident with done.
      if (bus.flush_i) cache_valid_d = 1'b0;
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         last_q        <= 1'b1;
         gnt_q         <= 1'b0;
         cache_valid_q <= 1'b0;
         flush_seen_q  <= 1'b0;
         cache_key_q   <= '0;
         kx_key_q      <= '0;
         rsp_valid_q   <= 2'b00;
         rsp_hit_q     <= 1'b0;
         kx_start_q    <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         last_q        <= last_d;
         gnt_q         <= gnt_d;
         cache_valid_q <= cache_valid_d;
         flush_seen_q  <= flush_seen_d;
         cache_key_q   <= cache_key_d;
         kx_key_q      <= kx_key_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_hit_q     <= rsp_hit_d;
         kx_start_q    <= kx_start_d;
         busy_q        <= busy_d;
      end
   end

   assign bus.req_ready_o = ready;
   assign bus.rsp_valid_o = rsp_valid_q;
   assign bus.rsp_hit_o   = rsp_hit_q;
   assign bus.kx_start_o  = kx_start_q;
   assign bus.kx_key_o    = kx_key_q;
   assign bus.busy_o      = busy_q;
   assign bus.round_key_o = bus.kx_round_key_i;

endmodule
